// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV control path: opcodes, FSM states,
// instruction classes and the per-class ALU control lookup.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_JALR = 7'b0011011;
   localparam logic [6:0] OP_CUST = 7'b0001011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_JUMP   = 3'd5,
      ST_TRAP   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CL_NONE   = 3'd0,
      CL_ALU_R  = 3'd1,
      CL_ALU_RD = 3'd2,
      CL_ALU_I  = 3'd3,
      CL_BRI    = 3'd4,
      CL_JALR   = 3'd5,
      CL_STORE  = 3'd6
   } class_e;

   typedef struct packed {
      logic alu_src;
      logic alu_d;
   } alu_ctl_t;

   // ALU operand/operation selects that a class holds through EXEC and WB.
   function automatic alu_ctl_t class_alu_ctl(input class_e cls);
      alu_ctl_t ctl;
      ctl = '0;
      case (cls)
         CL_ALU_RD: ctl.alu_d   = 1'b1;
         CL_ALU_I,
         CL_BRI,
         CL_JALR,
         CL_STORE:  ctl.alu_src = 1'b1;
         default:   ctl = '0;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/insn_class_decode.sv
// Combinational {op,funct3} -> instruction class lookup; valid_o low for any
// encoding this core does not implement.
module insn_class_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   output class_e     class_o,
   output logic       valid_o
);

   always_comb begin
      class_o = CL_NONE;
      case (op_i)
         OP_R: begin
            case (funct3_i)
               3'b000:                 class_o = CL_ALU_R;
               3'b010, 3'b111, 3'b101: class_o = CL_ALU_RD;
               default:                class_o = CL_NONE;
            endcase
         end
         OP_I: begin
            case (funct3_i)
               3'b000:         class_o = CL_BRI;
               3'b010, 3'b111: class_o = CL_ALU_I;
               default:        class_o = CL_NONE;
            endcase
         end
         OP_CUST: class_o = CL_ALU_I;
         OP_JALR: class_o = CL_JALR;
         OP_S:    class_o = (funct3_i == 3'b010) ? CL_STORE : CL_NONE;
         default: class_o = CL_NONE;
      endcase
      valid_o = (class_o != CL_NONE);
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer: fetch/decode/execute/memory/writeback with one shared
// req/ready memory port, wait-cycle timeout and sticky error flags.
//
//   state  | meaning
//   FETCH  | request instruction at PC; on ready load IR and PC+4
//   DECODE | latch instruction class, trap on unsupported encoding
//   EXEC   | ALU operating on class operands
//   MEM    | store access at ALU address, wait for ready
//   WB     | register write-back, instruction retires
//   JUMP   | link write + PC target write, instruction retires
//   TRAP   | everything idle until rst
module multicycle_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       RegW,
   output logic       ALUSrc,
   output logic       ALUD,
   output logic       MemW,
   output logic       Jalr,
   output logic       PCSrc,
   output logic       instr_done,
   output logic       illegal,
   output logic       bus_err,
   output logic [2:0] state_o
);

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
   localparam logic            TO_EN  = (MEM_TIMEOUT != 0);

   state_e            state_q, state_d;
   class_e            class_q, class_d;
   logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              wait_cyc, timeout_hit;
   class_e            dec_class;
   logic              dec_valid;
   alu_ctl_t          ctl;

   insn_class_decode u_decode (
      .op_i     (op),
      .funct3_i (funct3),
      .class_o  (dec_class),
      .valid_o  (dec_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         class_q   <= CL_NONE;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Only FETCH and MEM hold mem_req, so a wait cycle is one of those without ready.
   assign wait_cyc    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
   assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timeout_hit = TO_EN && wait_cyc && (cnt_inc == TO_LIM);

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready) begin
               state_d = ST_DECODE;
            end else if (timeout_hit) begin
               state_d   = ST_TRAP;
               bus_err_d = 1'b1;
            end
         end
         ST_DECODE: begin
            class_d = dec_valid ? dec_class : CL_NONE;
            if (dec_valid) begin
               state_d = ST_EXEC;
            end else begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end
         end
         ST_EXEC: begin
            case (class_q)
               CL_ALU_R, CL_ALU_RD, CL_ALU_I: state_d = ST_WB;
               CL_STORE:                      state_d = ST_MEM;
               CL_BRI, CL_JALR:               state_d = ST_JUMP;
               default:                       state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (timeout_hit) begin
               state_d   = ST_TRAP;
               bus_err_d = 1'b1;
            end
         end
         ST_WB, ST_JUMP: state_d = ST_FETCH;
         ST_TRAP:        state_d = ST_TRAP;
         default:        state_d = ST_TRAP;
      endcase

      cnt_d = cnt_q;
      if (wait_cyc) begin
         cnt_d = cnt_inc;
      end
      if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
         cnt_d = '0;
      end
   end

   assign ctl = class_alu_ctl(class_q);

   always_comb begin
      mem_req      = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      RegW         = 1'b0;
      ALUSrc       = 1'b0;
      ALUD         = 1'b0;
      MemW         = 1'b0;
      Jalr         = 1'b0;
      PCSrc        = 1'b0;
      instr_done   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
         end
         ST_EXEC: begin
            ALUSrc = ctl.alu_src;
            ALUD   = ctl.alu_d;
         end
         ST_WB: begin
            RegW       = 1'b1;
            ALUSrc     = ctl.alu_src;
            ALUD       = ctl.alu_d;
            instr_done = 1'b1;
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            ALUSrc       = 1'b1;
            MemW         = 1'b1;
            instr_done   = mem_ready;
         end
         ST_JUMP: begin
            RegW       = 1'b1;
            pc_we      = 1'b1;
            PCSrc      = 1'b1;
            ALUSrc     = 1'b1;
            Jalr       = (class_q == CL_JALR);
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // A reset cycle must never let a partial store or register write through.
      if (rst) begin
         mem_req      = 1'b0;
         mem_addr_sel = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         RegW         = 1'b0;
         ALUSrc       = 1'b0;
         ALUD         = 1'b0;
         MemW         = 1'b0;
         Jalr         = 1'b0;
         PCSrc        = 1'b0;
         instr_done   = 1'b0;
      end
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle scoreboard bench: each scenario queues its stimulus with the
// expected control word, then replays the queue and compares per cycle.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_addr_sel, ir_we, pc_we, RegW, ALUSrc, ALUD;
   logic       MemW, Jalr, PCSrc, instr_done, illegal, bus_err;
   logic [2:0] state_o;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [12:0] F_REQ   = 13'h1000;
   localparam logic [12:0] F_SEL   = 13'h0800;
   localparam logic [12:0] F_IRW   = 13'h0400;
   localparam logic [12:0] F_PCW   = 13'h0200;
   localparam logic [12:0] F_REGW  = 13'h0100;
   localparam logic [12:0] F_SRC   = 13'h0080;
   localparam logic [12:0] F_ALUD  = 13'h0040;
   localparam logic [12:0] F_MEMW  = 13'h0020;
   localparam logic [12:0] F_JALR  = 13'h0010;
   localparam logic [12:0] F_PCSRC = 13'h0008;
   localparam logic [12:0] F_DONE  = 13'h0004;
   localparam logic [12:0] F_ILL   = 13'h0002;
   localparam logic [12:0] F_BERR  = 13'h0001;

   localparam logic [12:0] FETCH_HIT = F_REQ | F_IRW | F_PCW;
   localparam logic [12:0] MEM_WAIT  = F_REQ | F_SEL | F_SRC | F_MEMW;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [15:0] exp;
   } item_t;

   item_t sb_q[$];

   multicycle_control_fsm #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .op           (op),
      .funct3       (funct3),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .RegW         (RegW),
      .ALUSrc       (ALUSrc),
      .ALUD         (ALUD),
      .MemW         (MemW),
      .Jalr         (Jalr),
      .PCSrc        (PCSrc),
      .instr_done   (instr_done),
      .illegal      (illegal),
      .bus_err      (bus_err),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] obs();
      return {state_o, mem_req, mem_addr_sel, ir_we, pc_we, RegW, ALUSrc, ALUD,
              MemW, Jalr, PCSrc, instr_done, illegal, bus_err};
   endfunction

   task automatic push(input logic r, input logic rd, input logic [6:0] o,
                       input logic [2:0] f, input logic [2:0] st, input logic [12:0] fl);
      item_t it;
      it.rst = r; it.rdy = rd; it.op = o; it.f3 = f; it.exp = {st, fl};
      sb_q.push_back(it);
   endtask

   task automatic drive(input item_t it);
      @(negedge clk);
      rst = it.rst; mem_ready = it.rdy; op = it.op; funct3 = it.f3;
      #1;
   endtask

   task automatic test_reset();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1;
      push(1, 1, 7'b0110011, 3'b000, 3'd0, 13'h0);
      push(0, 0, 7'b0110011, 3'b000, 3'd0, F_REQ);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL reset cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_r_add();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(0, 1, 7'b0110011, 3'b000, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0110011, 3'b000, 3'd1, 13'h0);
      push(0, 1, 7'b0110011, 3'b000, 3'd2, 13'h0);
      push(0, 1, 7'b0110011, 3'b000, 3'd4, F_REGW | F_DONE);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL r_add cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_i_delayed_fetch();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      for (int i = 0; i < 3; i++) push(0, 0, 7'b0010011, 3'b111, 3'd0, F_REQ);
      push(0, 1, 7'b0010011, 3'b111, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0010011, 3'b111, 3'd1, 13'h0);
      push(0, 1, 7'b0010011, 3'b111, 3'd2, F_SRC);
      push(0, 1, 7'b0010011, 3'b111, 3'd4, F_REGW | F_SRC | F_DONE);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL i_delay cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_store();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(0, 1, 7'b0100011, 3'b010, 3'd0, FETCH_HIT);
      push(0, 0, 7'b0100011, 3'b010, 3'd1, 13'h0);
      push(0, 1, 7'b0100011, 3'b010, 3'd2, F_SRC);
      push(0, 0, 7'b0100011, 3'b010, 3'd3, MEM_WAIT);
      push(0, 0, 7'b0100011, 3'b010, 3'd3, MEM_WAIT);
      push(0, 1, 7'b0100011, 3'b010, 3'd3, MEM_WAIT | F_DONE);
      push(0, 0, 7'b0100011, 3'b010, 3'd0, F_REQ);
      push(0, 1, 7'b0100011, 3'b010, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0100011, 3'b010, 3'd1, 13'h0);
      push(0, 1, 7'b0100011, 3'b010, 3'd2, F_SRC);
      push(0, 1, 7'b0100011, 3'b010, 3'd3, MEM_WAIT | F_DONE);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL store cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_jump();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(0, 1, 7'b0011011, 3'b101, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0011011, 3'b101, 3'd1, 13'h0);
      push(0, 1, 7'b0011011, 3'b101, 3'd2, F_SRC);
      push(0, 1, 7'b0011011, 3'b101, 3'd5, F_REGW | F_PCW | F_PCSRC | F_SRC | F_JALR | F_DONE);
      push(0, 1, 7'b0010011, 3'b000, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0010011, 3'b000, 3'd1, 13'h0);
      push(0, 1, 7'b0010011, 3'b000, 3'd2, F_SRC);
      push(0, 1, 7'b0010011, 3'b000, 3'd5, F_REGW | F_PCW | F_PCSRC | F_SRC | F_DONE);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL jump cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(0, 1, 7'b0110011, 3'b101, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0110011, 3'b101, 3'd1, 13'h0);
      push(0, 1, 7'b0110011, 3'b101, 3'd2, F_ALUD);
      push(0, 1, 7'b0110011, 3'b101, 3'd4, F_REGW | F_ALUD | F_DONE);
      push(0, 1, 7'b0001011, 3'b011, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0001011, 3'b011, 3'd1, 13'h0);
      push(0, 1, 7'b0001011, 3'b011, 3'd2, F_SRC);
      push(0, 1, 7'b0001011, 3'b011, 3'd4, F_REGW | F_SRC | F_DONE);
      push(0, 1, 7'b0110011, 3'b000, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0110011, 3'b000, 3'd1, 13'h0);
      push(0, 1, 7'b0110011, 3'b000, 3'd2, 13'h0);
      push(0, 1, 7'b0110011, 3'b000, 3'd4, F_REGW | F_DONE);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL b2b cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_illegal();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(0, 1, 7'b0110011, 3'b001, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0110011, 3'b001, 3'd1, 13'h0);
      for (int i = 0; i < 20; i++) push(0, 1'(i % 2), 7'b0110011, 3'b001, 3'd7, F_ILL);
      push(1, 0, 7'b0110011, 3'b001, 3'd7, F_ILL);
      push(0, 0, 7'b0110011, 3'b001, 3'd0, F_REQ);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL illegal cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_timeout();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(1, 0, 7'b0110011, 3'b000, 3'd0, 13'h0);
      for (int i = 0; i < 4; i++) push(0, 0, 7'b0110011, 3'b000, 3'd0, F_REQ);
      push(0, 0, 7'b0110011, 3'b000, 3'd7, F_BERR);
      push(0, 1, 7'b0110011, 3'b000, 3'd7, F_BERR);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL timeout cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_rst_mid_store();
      item_t it;
      logic [15:0] got;
      int cyc = 0;
      push(1, 0, 7'b0100011, 3'b010, 3'd7, F_BERR);
      push(0, 1, 7'b0100011, 3'b010, 3'd0, FETCH_HIT);
      push(0, 1, 7'b0100011, 3'b010, 3'd1, 13'h0);
      push(0, 1, 7'b0100011, 3'b010, 3'd2, F_SRC);
      push(0, 0, 7'b0100011, 3'b010, 3'd3, MEM_WAIT);
      push(1, 0, 7'b0100011, 3'b010, 3'd3, 13'h0);
      push(1, 0, 7'b0100011, 3'b010, 3'd0, 13'h0);
      push(0, 1, 7'b0100011, 3'b010, 3'd0, FETCH_HIT);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         drive(it);
         got = obs();
         n_total++;
         if (got !== it.exp) $display("FAIL rst_store cyc %0d: got st=%0d fl=%b want st=%0d fl=%b", cyc, got[15:13], got[12:0], it.exp[15:13], it.exp[12:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_i_delayed_fetch();
      test_store();
      test_jump();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_rst_mid_store();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
